vscpu2_core: RTL and testbench
==============================

// Module: vscpu2_core
// PURPOSE
//  Second-generation multi-cycle memory-to-memory CPU core: 16-opcode ISA (ADD..MULi) on operands held in RAM.
//  Parametrised address/data width, req/rdy memory handshake with wait states, run gating, halt on self-branch, retired-instruction counter.
//  Sits between the system RAM (or bus arbiter) and the top level; the sole memory master of its port.
// PARAMETERS
//  ADDR_W   14  word-address width; instruction fields A, B are ADDR_W bits each
//  DATA_W   32  data/instruction word width; must be >= 2*ADDR_W+4 (elaboration error otherwise)
//  CNT_W    32  width of instret counter
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-low reset (0 = reset)
//  run        in   1       1 = fetch allowed; sampled only in IDLE
//  mem_req    out  1       memory access request, held until mem_rdy
//  mem_we     out  1       1 = write, 0 = read; valid with mem_req
//  mem_addr   out  ADDR_W  word address; valid with mem_req
//  mem_wdata  out  DATA_W  write data; valid with mem_req & mem_we
//  mem_rdy    in   1       access completes in the cycle mem_req & mem_rdy
//  mem_rdata  in   DATA_W  read data, valid in the completing cycle of a read
//  halted     out  1       sticky; set on self-branch, cleared only by reset
//  instret    out  CNT_W   count of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Format: opc=iw[2A+3:2A], A=iw[2A-1:A], B=iw[A-1:0] (A=ADDR_W); bits above 2A+3 ignored. *X = mem[X]; imm B zero-extended.
//  ISA: 0 ADD *A=*A+*B | 1 ADDi *A=*A+B | 2 NAND *A=~(*A&*B) | 3 NANDi *A=~(*A&B)
//   4 SRL s=*B: *A = s<DATA_W ? *A>>s : *A<<(s-DATA_W) (result 0 once s-DATA_W >= DATA_W) | 5 SRLi same, s=B
//   6 LT *A=(*A<*B) unsigned | 7 LTi *A=(*A<B) | 8 CP *A=*B | 9 CPi *A=B
//   10 CPI *A=*(*B) | 11 CPIi *(*A)=*B | 12 BZJ pc = (*B==0) ? *A[A-1:0] : pc+1 | 13 BZJi pc=(*A+B)[A-1:0]
//   14 MUL *A=low DATA_W of *A * *B | 15 MULi *A=low DATA_W of *A*B. All non-branch ops: pc=pc+1 (mod 2^ADDR_W).
//  States: IDLE -> FETCH -> RD_A -> RD_B -> RD_IND -> WB -> IDLE; HALT terminal.
//   IDLE: no req; if run go FETCH, else stay. FETCH: read pc, capture iw.
//   RD_A: read A; skipped by CP, CPi, CPI. RD_B: read B; skipped by *i except CPIi (reads B).
//   RD_IND: CPI reads *B-address; others skip. WB: write; BZJ/BZJi have no WB, update pc, retire.
//   CPIi WB: addr = *A[A-1:0], data = *B.
//  Each memory state holds mem_req=1 and stable addr/we/wdata until mem_rdy; advances the cycle after completion.
//  mem_rdata captured into opA/opB/iw registers on completion; no combinational path mem_rdy/mem_rdata -> mem_* outputs.
//  Latency with mem_rdy tied 1: 1 cycle per access + 1 IDLE cycle; ADD = 5 cycles, CPi = 3, BZJi = 3.
//  Retire: instret+1 and pc update in the cycle WB completes (branch: cycle its last read completes).
//  Halt: branch whose new pc equals its own pc -> retire, halted=1, enter HALT; no further req, run ignored.
//  run deasserted mid-instruction: current instruction completes; stops in IDLE.
//  Reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, instret=0, pc=0, iw/opA/opB=0, state IDLE.
//   Reset mid-access abandons the access in the same edge (mem_req=0 next cycle); a write may or may not have landed.
//  Address arithmetic truncates to ADDR_W; data arithmetic to DATA_W; no flags, no traps.
// STRUCTURE
//  vscpu2_pkg (include file): opcode localparams OP_ADD..OP_MULi, state encodings, field-slice helpers.
//  vscpu2_alu: combinational sub-module (opc, a, b, imm) -> result, branch-taken; core holds FSM, regs, handshake.
// TESTING
//  rdy=1, mem[0]=ADD 10,11, mem[10]=5, mem[11]=7 -> mem[10]=12 after 5 cycles, instret=1, pc=1.
//  rdy random 0..3 wait cycles on every access -> same final RAM as rdy=1 run; mem_* stable while req&!rdy.
//  SRL *A=0x80000000, *B=31 -> 1; *B=33 -> 0x00000000 shifted left by 1 gives 0 (DATA_W=32); SRLi B=4 on 0xF0 -> 0x0F.
//  CPI/CPIi: mem[20]=30, mem[30]=0xABCD, CPI 40,20 -> mem[40]=0xABCD; CPIi 20,40 -> mem[30]=0xABCD.
//  BZJi 50,0 with mem[50]=pc -> halted=1 next cycle, mem_req stays 0 for 100 cycles, instret frozen.
//  rst=0 for 1 cycle while mem_req&!mem_rdy in RD_B -> all outputs reset values, refetch from pc=0 when run=1.

Source files
------------

// File: rtl/vscpu2_pkg.sv
// Shared definitions for the vscpu2 core: opcodes, FSM states and per-opcode
// sequencing helpers that decide which memory phases an instruction needs.
package vscpu2_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDi  = 4'd1;
    localparam logic [3:0] OP_NAND  = 4'd2;
    localparam logic [3:0] OP_NANDi = 4'd3;
    localparam logic [3:0] OP_SRL   = 4'd4;
    localparam logic [3:0] OP_SRLi  = 4'd5;
    localparam logic [3:0] OP_LT    = 4'd6;
    localparam logic [3:0] OP_LTi   = 4'd7;
    localparam logic [3:0] OP_CP    = 4'd8;
    localparam logic [3:0] OP_CPi   = 4'd9;
    localparam logic [3:0] OP_CPI   = 4'd10;
    localparam logic [3:0] OP_CPIi  = 4'd11;
    localparam logic [3:0] OP_BZJ   = 4'd12;
    localparam logic [3:0] OP_BZJi  = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_MULi  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RD_A,
        ST_RD_B,
        ST_RD_IND,
        ST_WB,
        ST_HALT
    } state_e;

    function automatic logic readsA(input logic [3:0] opc);
        return !(opc inside {OP_CP, OP_CPi, OP_CPI});
    endfunction

    // Immediate forms carry B in the word itself, except CPIi which copies *B.
    function automatic logic readsB(input logic [3:0] opc);
        return !opc[0] || (opc == OP_CPIi);
    endfunction

    function automatic logic isBranch(input logic [3:0] opc);
        return opc inside {OP_BZJ, OP_BZJi};
    endfunction

    // Returns the phase following cur; ST_IDLE means a branch resolves now.
    function automatic state_e nextState(input state_e cur, input logic [3:0] opc);
        if (cur == ST_FETCH && readsA(opc))
            return ST_RD_A;
        if ((cur inside {ST_FETCH, ST_RD_A}) && readsB(opc))
            return ST_RD_B;
        if ((cur inside {ST_FETCH, ST_RD_A, ST_RD_B}) && opc == OP_CPI)
            return ST_RD_IND;
        if (isBranch(opc))
            return ST_IDLE;
        return ST_WB;
    endfunction

endpackage

// File: rtl/vscpu2_alu.sv
// Combinational datapath: computes the write-back value or, for branches,
// the target word and whether the branch is taken.
module vscpu2_alu
    import vscpu2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        opc_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              taken_o
);

    logic [DATA_W-1:0] rhs;

    assign rhs = opc_i[0] ? imm_i : b_i;

    always_comb begin
        result_o = '0;
        taken_o  = 1'b0;
        case (opc_i)
            OP_ADD, OP_ADDi:   result_o = a_i + rhs;
            OP_NAND, OP_NANDi: result_o = ~(a_i & rhs);
            OP_SRL, OP_SRLi: begin
                // Large shift amounts turn into a left shift that saturates to zero.
                if (rhs < DATA_W'(DATA_W))
                    result_o = a_i >> rhs;
                else
                    result_o = a_i << (rhs - DATA_W'(DATA_W));
            end
            OP_LT, OP_LTi:     result_o = {{(DATA_W-1){1'b0}}, (a_i < rhs)};
            OP_CP, OP_CPi, OP_CPI, OP_CPIi: result_o = rhs;
            OP_BZJ: begin
                result_o = a_i;
                taken_o  = (b_i == '0);
            end
            OP_BZJi: begin
                result_o = a_i + rhs;
                taken_o  = 1'b1;
            end
            OP_MUL, OP_MULi:   result_o = a_i * rhs;
            default: begin
                result_o = '0;
                taken_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vscpu2_core.sv
// Multi-cycle memory-to-memory CPU: one registered memory port with req/rdy
// handshake, sequencing FETCH/RD_A/RD_B/RD_IND/WB per opcode.
module vscpu2_core
    import vscpu2_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted,
    output logic [CNT_W-1:0]  instret
);

    if (DATA_W < 2*ADDR_W + 4) begin : gBadWidth
        $error("vscpu2_core: DATA_W must be at least 2*ADDR_W+4");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] iw_q, iw_d;
    logic [DATA_W-1:0] opA_q, opA_d;
    logic [DATA_W-1:0] opB_q, opB_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic [DATA_W-1:0] curIw, aVal, bVal, immExt, aluResult;
    logic [3:0]        opc;
    logic [ADDR_W-1:0] fieldA, fieldB, pcInc, pcNext;
    logic              aluTaken;
    state_e            stepState;

    // Operands arriving this cycle are bypassed so the next access can be set up
    // on the completion edge; they only feed registers, never the port directly.
    assign curIw  = (state_q == ST_FETCH) ? mem_rdata : iw_q;
    assign aVal   = (state_q == ST_RD_A) ? mem_rdata : opA_q;
    assign bVal   = (state_q inside {ST_RD_B, ST_RD_IND}) ? mem_rdata : opB_q;
    assign opc    = curIw[2*ADDR_W+3 -: 4];
    assign fieldA = curIw[2*ADDR_W-1 -: ADDR_W];
    assign fieldB = curIw[ADDR_W-1:0];
    assign immExt = {{(DATA_W-ADDR_W){1'b0}}, fieldB};
    assign pcInc  = pc_q + ADDR_W'(1);
    assign pcNext = aluTaken ? aluResult[ADDR_W-1:0] : pcInc;
    assign stepState = nextState(state_q, opc);

    if (DATA_W > 2*ADDR_W + 4) begin : gSpareBits
        logic unusedIwBits;
        assign unusedIwBits = ^curIw[DATA_W-1:2*ADDR_W+4];
    end

    vscpu2_alu #(.DATA_W(DATA_W)) uAlu (
        .opc_i    (opc),
        .a_i      (aVal),
        .b_i      (bVal),
        .imm_i    (immExt),
        .result_o (aluResult),
        .taken_o  (aluTaken)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            iw_q       <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            halted_q   <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iw_q       <= iw_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            halted_q   <= halted_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iw_d       = iw_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        halted_d   = halted_q;
        instret_d  = instret_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d   = ST_FETCH;
                    memReq_d  = 1'b1;
                    memWe_d   = 1'b0;
                    memAddr_d = pc_q;
                end
            end
            ST_FETCH, ST_RD_A, ST_RD_B, ST_RD_IND: begin
                if (mem_rdy) begin
                    if (state_q == ST_FETCH) iw_d  = mem_rdata;
                    if (state_q == ST_RD_A)  opA_d = mem_rdata;
                    if (state_q inside {ST_RD_B, ST_RD_IND}) opB_d = mem_rdata;
                    state_d = stepState;
                    memWe_d = 1'b0;
                    case (stepState)
                        ST_RD_A:   memAddr_d = fieldA;
                        ST_RD_B:   memAddr_d = fieldB;
                        ST_RD_IND: memAddr_d = bVal[ADDR_W-1:0];
                        ST_WB: begin
                            memWe_d    = 1'b1;
                            memAddr_d  = (opc == OP_CPIi) ? aVal[ADDR_W-1:0] : fieldA;
                            memWdata_d = (opc == OP_CPIi) ? bVal : aluResult;
                        end
                        ST_IDLE: begin
                            // Branch resolves on its last read; a self-branch parks the core.
                            memReq_d  = 1'b0;
                            instret_d = instret_q + CNT_W'(1);
                            pc_d      = pcNext;
                            if (pcNext == pc_q) begin
                                state_d  = ST_HALT;
                                halted_d = 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WB: begin
                if (mem_rdy) begin
                    state_d   = ST_IDLE;
                    memReq_d  = 1'b0;
                    memWe_d   = 1'b0;
                    pc_d      = pcInc;
                    instret_d = instret_q + CNT_W'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign halted    = halted_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_vscpu2_core.sv
// Scoreboard bench for vscpu2_core: an instruction-level model predicts every
// memory write; a memory responder with random wait states checks them as they land.
module tb_vscpu2_core;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          mem_req, mem_we;
    logic          mem_rdy = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          halted;
    logic [CW-1:0] instret;

    bit [31:0] ram    [MEMSZ];
    bit [31:0] refMem [MEMSZ];

    typedef struct {
        int        addr;
        bit [31:0] data;
    } wr_t;
    wr_t expQ[$];

    int checks = 0;
    int errors = 0;
    int maxWait = 0;
    int stallIdx = 0;
    int accessIdx = 0;
    int waitLeft = 0;
    bit armed = 0;
    bit prevStall = 0;
    logic [AW+DW:0] prevBus = '0;

    assign mem_rdata = ram[mem_addr];

    vscpu2_core #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdy   (mem_rdy),
        .mem_rdata (mem_rdata),
        .halted    (halted),
        .instret   (instret)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] mkInstr(input int opc, input int a, input int b);
        bit [3:0]  o = opc[3:0];
        bit [13:0] fa = a[13:0];
        bit [13:0] fb = b[13:0];
        return {o, fa, fb};
    endfunction

    function automatic bit [31:0] shiftModel(input bit [31:0] v, input bit [31:0] s);
        if (s < 32) return v >> s;
        if (s - 32 < 32) return v << (s - 32);
        return 32'h0;
    endfunction

    task automatic modelWrite(input int addr, input bit [31:0] d);
        wr_t e;
        refMem[addr] = d;
        e.addr = addr;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Instruction-set model: executes from a copy of RAM, queueing each write.
    task automatic runModel(output int retired);
        int pc, npc, opc, fa, fb;
        bit [31:0] iw, va, vb, immB, tmp;
        bit done;
        for (int i = 0; i < MEMSZ; i++) refMem[i] = ram[i];
        expQ.delete();
        retired = 0;
        pc = 0;
        done = 0;
        for (int step = 0; step < 4000 && !done; step++) begin
            iw   = refMem[pc];
            opc  = int'(iw[31:28]);
            fa   = int'(iw[27:14]);
            fb   = int'(iw[13:0]);
            immB = iw[13:0];
            va   = refMem[fa];
            vb   = refMem[fb];
            npc  = (pc + 1) % MEMSZ;
            retired++;
            case (opc)
                0:  modelWrite(fa, va + vb);
                1:  modelWrite(fa, va + immB);
                2:  modelWrite(fa, ~(va & vb));
                3:  modelWrite(fa, ~(va & immB));
                4:  modelWrite(fa, shiftModel(va, vb));
                5:  modelWrite(fa, shiftModel(va, immB));
                6:  modelWrite(fa, (va < vb) ? 32'd1 : 32'd0);
                7:  modelWrite(fa, (va < immB) ? 32'd1 : 32'd0);
                8:  modelWrite(fa, vb);
                9:  modelWrite(fa, immB);
                10: modelWrite(fa, refMem[int'(vb[13:0])]);
                11: modelWrite(int'(va[13:0]), vb);
                12: if (vb == 0) npc = int'(va[13:0]);
                13: begin tmp = va + immB; npc = int'(tmp[13:0]); end
                14: modelWrite(fa, va * vb);
                default: modelWrite(fa, va * immB);
            endcase
            if ((opc == 12 || opc == 13) && npc == pc) done = 1;
            pc = npc;
        end
    endtask

    // Memory slave plus write monitor, evaluated once per falling edge.
    task automatic serviceMemory();
        wr_t e;
        if (prevStall && mem_req)
            checkOutput("stable_bus_while_stalled", {mem_we, mem_addr, mem_wdata}, prevBus);
        if (!mem_req) begin
            mem_rdy = 1'b0;
            armed = 0;
        end else if (!armed || mem_rdy) begin
            accessIdx++;
            armed = 1;
            waitLeft = (stallIdx != 0 && accessIdx == stallIdx) ? 1000000 : int'($urandom_range(0, maxWait));
            mem_rdy = (waitLeft == 0);
        end else begin
            waitLeft--;
            mem_rdy = (waitLeft == 0);
        end
        prevStall = mem_req && !mem_rdy;
        prevBus = {mem_we, mem_addr, mem_wdata};
        if (mem_req && mem_rdy && mem_we) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = expQ.pop_front();
                checkOutput("write_addr", 64'(mem_addr), 64'(e.addr));
                checkOutput("write_data", 64'(mem_wdata), 64'(e.data));
            end
            ram[mem_addr] = mem_wdata;
        end
    endtask

    task automatic checkResetValues();
        checkOutput("reset_mem_req", 64'(mem_req), 64'(0));
        checkOutput("reset_mem_we", 64'(mem_we), 64'(0));
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        checkOutput("reset_halted", 64'(halted), 64'(0));
        checkOutput("reset_instret", 64'(instret), 64'(0));
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;
        checkResetValues();
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input int waitMax, output int expRetired);
        runModel(expRetired);
        maxWait = waitMax;
        accessIdx = 0;
        run = 1'b1;
    endtask

    task automatic finishRun(input int expRetired, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("halt_reached", 64'(halted), 64'(1));
        checkOutput("instret_final", 64'(instret), 64'(expRetired));
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
    endtask

    bit [31:0] progImg [17];
    bit [31:0] dataImg [16];
    bit [31:0] snapshot [16];

    task automatic loadRandomImage();
        for (int i = 0; i < 17; i++) ram[i] = progImg[i];
        for (int j = 0; j < 16; j++) ram[100 + j] = dataImg[j];
        ram[200] = 32'd16;
    endtask

    initial begin
        int exp;
        int reqCount;
        logic [CW-1:0] frozen;

        fork
            forever begin
                @(negedge clk);
                serviceMemory();
            end
        join_none

        doReset();

        // ADD latency with a zero-wait memory, then halt and stay quiet.
        ram[0] = mkInstr(0, 10, 11);
        ram[1] = mkInstr(13, 200, 0);
        ram[10] = 32'd5;
        ram[11] = 32'd7;
        ram[200] = 32'd1;
        applyStimulus(0, exp);
        repeat (4) @(posedge clk);
        #1 checkOutput("instret_before_wb", 64'(instret), 64'(0));
        @(posedge clk); #1;
        checkOutput("instret_after_5", 64'(instret), 64'(1));
        @(posedge clk); #1;
        checkOutput("fetch_pc1", {63'(mem_addr), mem_req}, {63'(1), 1'b1});
        finishRun(exp, 200);
        checkOutput("add_result", 64'(ram[10]), 64'(12));
        frozen = instret;
        reqCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (mem_req) reqCount++;
        end
        checkOutput("halt_no_req", 64'(reqCount), 64'(0));
        checkOutput("halt_instret_frozen", 64'(instret), 64'(frozen));
        checkOutput("halt_sticky", 64'(halted), 64'(1));

        // Shifts across the DATA_W boundary.
        doReset();
        ram[0] = mkInstr(4, 60, 61);
        ram[1] = mkInstr(4, 62, 63);
        ram[2] = mkInstr(4, 66, 67);
        ram[3] = mkInstr(5, 64, 4);
        ram[4] = mkInstr(13, 200, 0);
        ram[60] = 32'h8000_0000; ram[61] = 32'd31;
        ram[62] = 32'h8000_0000; ram[63] = 32'd33;
        ram[66] = 32'h3;         ram[67] = 32'd33;
        ram[64] = 32'hF0;
        ram[200] = 32'd4;
        applyStimulus(2, exp);
        finishRun(exp, 500);
        checkOutput("srl_31", 64'(ram[60]), 64'(1));
        checkOutput("srl_33_msb", 64'(ram[62]), 64'(0));
        checkOutput("srl_33_left", 64'(ram[66]), 64'(6));
        checkOutput("srli_4", 64'(ram[64]), 64'(32'h0F));

        // Indirect copies and conditional branch both ways.
        doReset();
        ram[0] = mkInstr(10, 40, 20);
        ram[1] = mkInstr(11, 20, 40);
        ram[2] = mkInstr(12, 71, 72);
        ram[3] = mkInstr(12, 71, 70);
        ram[4] = mkInstr(13, 200, 0);
        ram[20] = 32'd30; ram[30] = 32'hABCD; ram[40] = 32'h0;
        ram[70] = 32'd0;  ram[71] = 32'd4;    ram[72] = 32'd5;
        ram[200] = 32'd4;
        applyStimulus(1, exp);
        finishRun(exp, 500);
        checkOutput("cpi_result", 64'(ram[40]), 64'(32'hABCD));
        checkOutput("cpii_result", 64'(ram[30]), 64'(32'hABCD));

        // Reset while stalled in RD_B of the second instruction.
        doReset();
        ram[0] = mkInstr(0, 10, 11);
        ram[1] = mkInstr(0, 12, 13);
        ram[2] = mkInstr(13, 200, 0);
        ram[10] = 32'd5; ram[11] = 32'd7; ram[12] = 32'd1; ram[13] = 32'd2;
        ram[200] = 32'd2;
        stallIdx = 7;
        applyStimulus(0, exp);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 14'd13) break;
        end
        checkOutput("stalled_in_rd_b", {63'(mem_addr), mem_req}, {63'(13), 1'b1});
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;
        checkResetValues();
        rst = 1'b1;
        stallIdx = 0;
        applyStimulus(0, exp);
        @(posedge clk); #1;
        checkOutput("refetch_pc0", {63'(mem_addr), mem_req}, {63'(0), 1'b1});
        finishRun(exp, 200);
        checkOutput("rerun_add_a", 64'(ram[10]), 64'(19));
        checkOutput("rerun_add_b", 64'(ram[12]), 64'(3));

        // Random programs: zero-wait run versus random-wait run of the same image.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                int k, opc, fb;
                k = int'($urandom_range(0, 11));
                opc = (k < 10) ? k : k + 4;
                if (opc % 2 == 1)
                    fb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 16383));
                else
                    fb = 100 + int'($urandom_range(0, 15));
                progImg[i] = mkInstr(opc, 100 + int'($urandom_range(0, 15)), fb);
            end
            progImg[16] = mkInstr(13, 200, 0);
            for (int j = 0; j < 16; j++)
                dataImg[j] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom();
            doReset();
            loadRandomImage();
            applyStimulus(0, exp);
            finishRun(exp, 2000);
            for (int j = 0; j < 16; j++) snapshot[j] = ram[100 + j];
            doReset();
            loadRandomImage();
            applyStimulus(3, exp);
            finishRun(exp, 4000);
            for (int j = 0; j < 16; j++)
                checkOutput("wait_vs_nowait_ram", 64'(ram[100 + j]), 64'(snapshot[j]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
